// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg
//   Shared constants, FSM state type and a small index helper for the
//   1x8 round-robin burst scheduler.
//   No ports (package).
package demux_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Channel index arithmetic wraps naturally at eight channels.
    function automatic logic [SEL_W-1:0] ch_add(input logic [SEL_W-1:0] a,
                                                input logic [SEL_W-1:0] b);
        ch_add = a + b;
    endfunction

endpackage

// File: rtl/demux_1x8_rr_sched_rr_pick8.sv
// rr_pick8
//   Combinational round-robin pick: returns the first set bit of mask
//   searching upward from last+1, wrapping modulo 8.
//   Ports:
//     mask  in  8  candidate channels
//     last  in  3  previously granted channel (lowest priority now)
//     idx   out 3  chosen channel (0 when nothing is found)
//     found out 1  at least one mask bit was set
module rr_pick8
    import demux_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);

    logic [SEL_W-1:0] idx_s;
    logic             found_s;

    // Walk the eight positions after last; the first hit wins.
    always_comb begin
        idx_s   = 3'd0;
        found_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found_s && mask[ch_add(last, ch_add(3'd1, 3'(k)))]) begin
                found_s = 1'b1;
                idx_s   = ch_add(last, ch_add(3'd1, 3'(k)));
            end else begin
                found_s = found_s;
            end
        end
    end

    assign idx   = idx_s;
    assign found = found_s;

endmodule

// File: rtl/demux_1x8_rr_sched.sv
// demux_1x8_rr_sched
//   Round-robin burst scheduler in front of a 1x8 demux. Grants one
//   enabled+ready channel for BURST_LEN beats, then rotates.
//   Optional per-channel beat statistics: define DEMUX_SCHED_STATS_EN.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     en_mask   in  8     per-channel enable
//     in_data   in  WIDTH input beat; in_valid / in_ready handshake
//     out_ready in  8     per-channel sink ready
//     out_valid out 8     one-hot (or zero) channel valid
//     out_data  out 8*W   channel i at [i*WIDTH +: WIDTH]
//     sel       out 3     granted channel (demux select)
//     busy      out 1     high while a burst is granted
//     stats_clr in  1     (macro) clear all beat counters
//     beat_cnt  out 8*16  (macro) channel i counter at [i*16 +: 16]
module demux_1x8_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int BURST_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en_mask,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH-1:0]       out_valid,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]        sel,
`ifdef DEMUX_SCHED_STATS_EN
    input  logic                    stats_clr,
    output logic [NUM_CH*CNT_W-1:0] beat_cnt,
`endif
    output logic                    busy
);

    state_t                  state_r;
    logic [SEL_W-1:0]        sel_r;
    logic [SEL_W-1:0]        last_r;
    logic [7:0]              beat_r;
    logic                    busy_r;

    logic [NUM_CH-1:0]       eligible_s;
    logic [SEL_W-1:0]        pick_idx_s;
    logic                    pick_found_s;
    logic                    in_ready_s;
    logic [NUM_CH-1:0]       out_valid_s;
    logic [NUM_CH*WIDTH-1:0] out_data_s;
    logic                    hs_s;

    assign eligible_s = en_mask & out_ready;

    rr_pick8 u_pick (
        .mask  (eligible_s),
        .last  (last_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Datapath steering: only the granted slice carries data, no storage.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = {NUM_CH{1'b0}};
        out_data_s  = {(NUM_CH*WIDTH){1'b0}};
        if (state_r == GRANT) begin
            in_ready_s                                = out_ready[sel_r] & en_mask[sel_r];
            out_valid_s[sel_r]                        = in_valid & en_mask[sel_r];
            out_data_s[int'(sel_r)*WIDTH +: WIDTH]    = in_data;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign hs_s = in_valid & in_ready_s;

    // Grant FSM: pick in IDLE, count handshakes in GRANT, abort on disable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sel_r   <= 3'd0;
            last_r  <= 3'd7;
            beat_r  <= 8'd0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && pick_found_s) begin
                        sel_r   <= pick_idx_s;
                        last_r  <= pick_idx_s;
                        beat_r  <= 8'd0;
                        state_r <= GRANT;
                        busy_r  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!en_mask[sel_r]) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (hs_s) begin
                        beat_r <= beat_r + 8'd1;
                        if (beat_r == 8'(BURST_LEN - 1)) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign sel       = sel_r;
    assign busy      = busy_r;

`ifdef DEMUX_SCHED_STATS_EN
    logic [CNT_W-1:0]        cnt_r [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] beat_cnt_s;

    // Saturating per-channel handshake counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= 16'd0;
            end
        end else if (hs_s && (cnt_r[sel_r] != 16'hFFFF)) begin
            cnt_r[sel_r] <= cnt_r[sel_r] + 16'd1;
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        beat_cnt_s = {(NUM_CH*CNT_W){1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            beat_cnt_s[i*CNT_W +: CNT_W] = cnt_r[i];
        end
    end

    assign beat_cnt = beat_cnt_s;
`endif

endmodule
